// File: rtl/fir_sample_feeder_if.sv
// Sample-feeder bus: loader write port, playback control and the streaming output.
// FEEDER_LOOP_EN adds the loop_mode/stop controls.
interface fir_sample_feeder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   sample_idx;
`ifdef FEEDER_LOOP_EN
  logic              loop_mode;
  logic              stop;

  modport master (
    output wr_en, wr_addr, wr_data, start, len, out_ready, loop_mode, stop,
    input  out_valid, out_data, out_last, busy, done, sample_idx
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, start, len, out_ready, loop_mode, stop,
    output out_valid, out_data, out_last, busy, done, sample_idx
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, start, len, out_ready,
    input  out_valid, out_data, out_last, busy, done, sample_idx
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, start, len, out_ready,
    output out_valid, out_data, out_last, busy, done, sample_idx
  );
`endif
endinterface

// File: rtl/fir_sample_feeder.sv
// Plays a loaded sample block into a FIR core, then FLUSH_LEN zeros, then pulses done.
// Optional FEEDER_LOOP_EN: continuous looping over the block until stop.
module fir_sample_feeder #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 512,
  parameter int ADDR_W    = 9,
  parameter int FLUSH_LEN = 11
) (
  input  logic                clk,
  input  logic                rst,
  fir_sample_feeder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PLAY, FLUSH, DONE} state_t;

  localparam int              FL_W      = $clog2(FLUSH_LEN + 2);
  localparam logic [ADDR_W:0] LEN_MAX   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W+1)'(1);
  localparam logic [FL_W-1:0] FL_LAST   = FL_W'(FLUSH_LEN > 0 ? FLUSH_LEN - 1 : 0);
  localparam logic [FL_W-1:0] FL_PRE    = FL_W'(FLUSH_LEN > 1 ? FLUSH_LEN - 2 : 0);
  localparam logic            HAS_FLUSH = (FLUSH_LEN > 0);
  localparam logic            ONE_FLUSH = (FLUSH_LEN == 1);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   len_r, len_c, idx_nxt;
  logic [FL_W-1:0]   fl_cnt;
  logic              xfer, at_end, wrap, fin, loop_r, stop_now;

`ifdef FEEDER_LOOP_EN
  logic stop_r;
  assign stop_now = stop_r | bus.stop;
`else
  assign loop_r   = 1'b0;
  assign stop_now = 1'b0;
`endif

  assign len_c   = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
  assign xfer    = bus.out_valid & bus.out_ready;
  assign idx_nxt = bus.sample_idx + IDX_ONE;
  assign at_end  = (idx_nxt == len_r);
  assign wrap    = loop_r & ~stop_now & at_end;
  assign fin     = loop_r ? stop_now : at_end;

  // Loader writes only land while the block is not being played.
  always_ff @(posedge clk)
    if (bus.wr_en && (state == IDLE || state == DONE))
      mem[bus.wr_addr] <= bus.wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_last   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.sample_idx <= '0;
      len_r          <= '0;
      fl_cnt         <= '0;
`ifdef FEEDER_LOOP_EN
      loop_r         <= 1'b0;
      stop_r         <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start && bus.len != '0) begin
          state          <= PLAY;
          len_r          <= len_c;
          bus.busy       <= 1'b1;
          bus.out_valid  <= 1'b1;
          bus.sample_idx <= '0;
          // Forward a same-cycle write to address 0 so the first beat sees it.
          bus.out_data   <= (bus.wr_en && bus.wr_addr == '0) ? bus.wr_data : mem[0];
`ifdef FEEDER_LOOP_EN
          loop_r         <= bus.loop_mode;
          stop_r         <= 1'b0;
          bus.out_last   <= !HAS_FLUSH && !bus.loop_mode && (len_c == IDX_ONE);
`else
          bus.out_last   <= !HAS_FLUSH && (len_c == IDX_ONE);
`endif
        end
        PLAY: begin
`ifdef FEEDER_LOOP_EN
          if (bus.stop) stop_r <= 1'b1;
`endif
          if (xfer) begin
            if (wrap) begin
              bus.sample_idx <= '0;
              bus.out_data   <= mem[0];
            end else if (!fin) begin
              bus.sample_idx <= idx_nxt;
              bus.out_data   <= mem[idx_nxt[ADDR_W-1:0]];
              bus.out_last   <= !HAS_FLUSH && !loop_r && (idx_nxt + IDX_ONE == len_r);
            end else if (HAS_FLUSH) begin
              state          <= FLUSH;
              bus.sample_idx <= len_r;
              bus.out_data   <= '0;
              bus.out_last   <= ONE_FLUSH;
              fl_cnt         <= '0;
            end else begin
              state          <= DONE;
              bus.out_valid  <= 1'b0;
              bus.out_data   <= '0;
              bus.out_last   <= 1'b0;
              bus.busy       <= 1'b0;
              bus.done       <= 1'b1;
            end
          end
        end
        FLUSH: if (xfer) begin
          if (fl_cnt == FL_LAST) begin
            state          <= DONE;
            bus.out_valid  <= 1'b0;
            bus.out_last   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
          end else begin
            fl_cnt         <= fl_cnt + 1'b1;
            bus.sample_idx <= idx_nxt;
            bus.out_last   <= (fl_cnt == FL_PRE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_sample_feeder.sv
// Randomized bench for fir_sample_feeder against a queue-based expected-beat model.
module tb_fir_sample_feeder;
  localparam int DATA_W = 16, DEPTH = 512, ADDR_W = 9, FLUSH_LEN = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_sample_feeder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();
  fir_sample_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FLUSH_LEN(FLUSH_LEN))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [DATA_W-1:0] data;
    int                idx;
    bit                last;
  } beat_t;

  beat_t             q[$];
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [DATA_W-1:0] got[$];
  int                got_idx[$];
  int  checks = 0, failures = 0, done_cnt = 0, rmode = 0, rcnt = 0, loop_beats = 0;
  bit  chk_en = 0, done_due = 0, idle_now = 1, busy_now = 0;

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Expected beat list: the clamped block (or loop_beats wrapped beats), then the zero tail.
  function automatic void build(int n, bit lp);
    int    l, beats;
    beat_t b;
    l     = (n > DEPTH) ? DEPTH : n;
    beats = lp ? loop_beats : l;
    for (int i = 0; i < beats; i++) begin
      b.data = mem_m[i % l]; b.idx = i % l; b.last = (FLUSH_LEN == 0) && (i == beats - 1);
      q.push_back(b);
    end
    for (int i = 0; i < FLUSH_LEN; i++) begin
      b.data = '0; b.idx = l + i; b.last = (i == FLUSH_LEN - 1);
      q.push_back(b);
    end
  endfunction

  // Model update on the active edge, using inputs driven 1ns after the previous edge.
  always @(posedge clk) begin
    bit lp;
    lp = 1'b0;
`ifdef FEEDER_LOOP_EN
    lp = bus.loop_mode;
`endif
    if (rst) begin
      q.delete();
      done_due = 0;
    end else begin
      if (bus.wr_en && !busy_now) mem_m[bus.wr_addr] = bus.wr_data;
      if (bus.start && idle_now && bus.len != '0) build(int'(bus.len), lp);
    end
  end

  // Compare process: outputs checked every cycle on the falling edge.
  always @(negedge clk) begin
    bit exp_v, pl;
    exp_v    = (q.size() > 0);
    idle_now = !exp_v && !done_due;
    busy_now = exp_v;
    pl       = 0;
    if (chk_en && !rst) begin
      check("out_valid", bus.out_valid, exp_v);
      check("busy", bus.busy, exp_v);
      check("done", bus.done, done_due);
      if (bus.done) done_cnt++;
      if (exp_v) begin
        check("out_data", bus.out_data, q[0].data);
        check("sample_idx", bus.sample_idx, q[0].idx);
        check("out_last", bus.out_last, q[0].last);
        if (bus.out_ready) begin
          got.push_back(bus.out_data);
          got_idx.push_back(int'(bus.sample_idx));
          void'(q.pop_front());
          pl = (q.size() == 0);
        end
      end
    end
    done_due = pl;
  end

  // Downstream ready: 0 = always, 1 = 1,0,0 repeating, else random.
  always @(posedge clk) begin
    #1;
    rcnt++;
    case (rmode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (rcnt % 3 == 0);
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(int a, int d);
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(a); bus.wr_data = DATA_W'(d);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic go(int n);
    tick();
    bus.start = 1'b1; bus.len = (ADDR_W+1)'(n);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    tick();
    while (!idle_now && n < budget) begin tick(); n++; end
    check("idle_timeout", idle_now, 1);
  endtask

  task automatic check_basic(string tag);
    check({tag, "_beats"}, got.size(), 4 + FLUSH_LEN);
    if (got.size() == 4 + FLUSH_LEN) begin
      for (int i = 0; i < 4; i++) begin
        check({tag, "_data"}, got[i], i + 1);
        check({tag, "_idx"}, got_idx[i], i);
      end
      check({tag, "_tail_data"}, got[14], 0);
      check({tag, "_tail_idx"}, got_idx[14], 14);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0, l;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 0; bus.len = '0;
    bus.out_ready = 0;
`ifdef FEEDER_LOOP_EN
    bus.loop_mode = 0; bus.stop = 0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_idx", bus.sample_idx, 0);
    @(posedge clk); #1;
    rst = 1'b0; chk_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(0, 65535)));
    for (int i = 0; i < 4; i++) wr(i, i + 1);

    // Full-rate single pass, then the same block under a stalling consumer.
    rmode = 0; got.delete(); got_idx.delete(); d0 = done_cnt;
    go(4); wait_idle(100);
    check_basic("fullrate"); check("fullrate_done", done_cnt - d0, 1);
    rmode = 1; got.delete(); got_idx.delete(); d0 = done_cnt;
    go(4); wait_idle(200);
    check_basic("stall"); check("stall_done", done_cnt - d0, 1);

    // len=0 is ignored; oversize len clamps to the memory depth.
    rmode = 0; got.delete(); d0 = done_cnt;
    go(0); repeat (5) tick();
    check("len0_beats", got.size(), 0); check("len0_done", done_cnt - d0, 0);
    rmode = 2; got.delete(); got_idx.delete();
    go(600); wait_idle(4000);
    check("clamp_beats", got.size(), DEPTH + FLUSH_LEN);
    if (got_idx.size() == DEPTH + FLUSH_LEN) begin
      check("clamp_last_sample_idx", got_idx[DEPTH-1], DEPTH - 1);
      check("clamp_tail_idx", got_idx[DEPTH+FLUSH_LEN-1], DEPTH + FLUSH_LEN - 1);
    end

    // Writes and starts during playback have no effect.
    rmode = 0;
    go(4); tick(); wr(0, 'h7FFF); go(2); wait_idle(100);
    got.delete(); got_idx.delete();
    go(4); wait_idle(100);
    check_basic("busy_ignore");

    // Reset while beat 2 is on the bus aborts without done.
    d0 = done_cnt;
    go(4); tick(); tick();
    rst = 1'b1; tick();
    check("abort_valid", bus.out_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_idx", bus.sample_idx, 0);
    check("abort_data", bus.out_data, 0);
    rst = 1'b0; repeat (3) tick();
    check("abort_done", done_cnt - d0, 0);
    got.delete(); got_idx.delete();
    go(4); wait_idle(100);
    check_basic("after_abort");

    // Write and start in the same idle cycle: first beat carries the new word.
    rmode = 2; got.delete();
    tick();
    bus.wr_en = 1; bus.wr_addr = '0; bus.wr_data = 16'h1234; bus.start = 1; bus.len = 10'd5;
    tick();
    bus.wr_en = 0; bus.start = 0;
    wait_idle(200);
    check("fwd_first", got.size() > 0 ? got[0] : 0, 'h1234);

    // Random lengths, contents and backpressure.
    for (int k = 0; k < 8; k++) begin
      l = $urandom_range(1, 40);
      for (int j = 0; j < 3; j++) wr($urandom_range(0, 39), int'($urandom_range(0, 65535)));
      rmode = (k % 2 == 0) ? 2 : 0;
      got.delete();
      go(l); wait_idle(500);
      check("rand_beats", got.size(), l + FLUSH_LEN);
    end

`ifdef FEEDER_LOOP_EN
    // Loop over 5,6,7; stop lands with the seventh beat.
    wr(0, 5); wr(1, 6); wr(2, 7);
    rmode = 0; loop_beats = 7; got.delete(); got_idx.delete(); d0 = done_cnt;
    bus.loop_mode = 1'b1;
    go(3);
    bus.loop_mode = 1'b0;
    repeat (6) tick();
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    wait_idle(100);
    check("loop_beats", got.size(), 7 + FLUSH_LEN);
    if (got.size() == 7 + FLUSH_LEN) begin
      check("loop_b3", got[3], 5);
      check("loop_b6", got[6], 5);
      check("loop_i6", got_idx[6], 0);
      check("loop_tail", got[7], 0);
      check("loop_tail_idx", got_idx[7], 3);
    end
    check("loop_done", done_cnt - d0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
